// File: rtl/router_input_buffer.sv
// router_input_buffer
//   Per-direction input FIFO of the 5-port mesh router, upstream of the arbiter.
//   Buffers incoming flits, presents the head flit, its destination address and an
//   empty flag to the arbiter, pops on the arbiter's read strobe and returns one
//   credit pulse upstream per freed slot.
//
// Ports
//   clk            router clock, all state on posedge
//   reset          asynchronous active-high reset
//   in_valid_i     upstream writes in_flit_i this cycle
//   in_flit_i      incoming flit
//   credit_o       registered one-cycle pulse: one slot freed
//   arb_read_i     arbiter pop strobe
//   arb_empty_o    FIFO empty
//   arb_address_o  head flit address field (valid when !arb_empty_o)
//   flit_o         head flit (valid when !arb_empty_o)
//   count_o        current occupancy
//   overflow_o     sticky: push while full without a pop
//   underflow_o    sticky: read strobe while empty
//   peak_o         max occupancy since reset (only with ROUTER_INBUF_PEAK_EN)
//
// Optional feature macro: ROUTER_INBUF_PEAK_EN adds peak_o and its register.
module router_input_buffer #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned ADDR_LSB   = 0,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid_i,
   input  logic [FLIT_WIDTH-1:0]        in_flit_i,
   output logic                         credit_o,
   input  logic                         arb_read_i,
   output logic                         arb_empty_o,
   output logic [7:0]                   arb_address_o,
   output logic [FLIT_WIDTH-1:0]        flit_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         overflow_o,
   output logic                         underflow_o
`ifdef ROUTER_INBUF_PEAK_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   peak_o
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  credit_q;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  full, empty;
   logic                  push, pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));

   // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted
   // when it coincides with a pop.
   assign pop  = arb_read_i && !empty;
   assign push = in_valid_i && (!full || pop);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      if (in_valid_i && full && !pop) begin
         overflow_d = 1'b1;
      end
      if (arb_read_i && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         credit_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         credit_q    <= pop;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately not reset; contents are qualified by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_flit_i;
      end
   end

   assign flit_o        = mem_q[rd_ptr_q];
   assign arb_address_o = flit_o[ADDR_LSB +: 8];
   assign arb_empty_o   = empty;
   assign count_o       = count_q;
   assign credit_o      = credit_q;
   assign overflow_o    = overflow_q;
   assign underflow_o   = underflow_q;

`ifdef ROUTER_INBUF_PEAK_EN
   logic [CntW-1:0] peak_q;

   // Tracks the registered count, so the peak lags a count change by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_q <= '0;
      end else if (count_q > peak_q) begin
         peak_q <= count_q;
      end
   end

   assign peak_o = peak_q;
`endif

endmodule
